// File: rtl/membus_pkg.sv
// Shared types and address map for the 9-bit memory/GPIO bus.
// Used by the bus initiator and its burst counter.
package membus_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  localparam logic [ADDR_W-1:0] RAM_BASE  = 9'h000;
  localparam logic [ADDR_W-1:0] RAM_LAST  = 9'h0FF;
  localparam logic [ADDR_W-1:0] GPIO_BASE = 9'h100;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LEN_W-1:0]  len;
  } req_t;

  // Anything above the last GPIO word is unmapped on this bus.
  function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
    return addr <= (GPIO_BASE + ADDR_W'(1));
  endfunction

endpackage

// File: rtl/membus_master_if.sv
// Requester, response and responder-side signals of the bus initiator.
// master = initiator view; slave = combined requester/responder view.
interface membus_master_if #(
  parameter int width  = 16,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [width-1:0]  req_wdata;
  logic [LEN_W-1:0]  req_len;

  logic              rsp_valid;
  logic [width-1:0]  rsp_rdata;
  logic              rsp_last;

  logic [ADDR_W-1:0] bus_addr;
  logic [width-1:0]  bus_data_write;
  logic              bus_w_strobe;
  logic [width-1:0]  bus_data_read;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_len, bus_data_read,
    output req_ready, rsp_valid, rsp_rdata, rsp_last,
    output bus_addr, bus_data_write, bus_w_strobe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_len, bus_data_read,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last,
    input  bus_addr, bus_data_write, bus_w_strobe
  );

endinterface

// File: rtl/membus_burst_ctr.sv
// Burst address/beat counter: loads start+1 and beat count, steps once per issued beat, wraps the address.
// Latency: outputs registered, valid the cycle after load/step; no backpressure.
module membus_burst_ctr #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              done
);

  logic [LEN_W-1:0] remain;

  // The first beat is issued straight from the request, so the counter starts one ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr + ADDR_W'(1);
      remain <= load_len;
    end else if (step && (remain != '0)) begin
      addr   <= addr + ADDR_W'(1);
      remain <= remain - LEN_W'(1);
    end
  end

  assign last = (remain == LEN_W'(1));
  assign done = (remain == '0);

endmodule

// File: rtl/membus_master.sv
// Bus initiator: one registered bus cycle per request, read data 2 cycles after accept; bursts with MEMBUS_BURST_EN.
// req_ready drops only while a burst is issuing; responses cannot be stalled.
module membus_master #(
  parameter int width  = 16,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
) (
  input logic             clk,
  input logic             reset,
  membus_master_if.master mb
);
  import membus_pkg::*;

  state_t            state;
  logic              ready_q;
  logic              strobe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [width-1:0]  wdata_q;
  logic              issue_rd;
  logic              issue_last;
  logic              rsp_vld_q;
  logic              rsp_last_q;
  logic              accept;

  assign accept = mb.req_valid && ready_q;

  assign mb.req_ready      = ready_q;
  assign mb.bus_addr       = addr_q;
  assign mb.bus_data_write = wdata_q;
  assign mb.bus_w_strobe   = strobe_q;
  assign mb.rsp_valid      = rsp_vld_q;
  assign mb.rsp_last       = rsp_last_q;
  // The responder registers read data, so it is already aligned with the pending flag.
  assign mb.rsp_rdata      = mb.bus_data_read;

`ifdef MEMBUS_BURST_EN
  logic              burst_start;
  logic              ctr_last;
  logic              ctr_done;
  logic [ADDR_W-1:0] ctr_addr;

  assign burst_start = accept && !mb.req_write && (mb.req_len != '0);

  membus_burst_ctr #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_burst_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (burst_start),
    .step     (state == BURST),
    .load_addr(mb.req_addr),
    .load_len (mb.req_len),
    .addr     (ctr_addr),
    .last     (ctr_last),
    .done     (ctr_done)
  );
`else
  logic unused_len;
  assign unused_len = ^mb.req_len;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      strobe_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      issue_rd   <= 1'b0;
      issue_last <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_last_q <= 1'b0;
    end else begin
      strobe_q   <= 1'b0;
      issue_rd   <= 1'b0;
      issue_last <= 1'b0;
      rsp_vld_q  <= issue_rd;
      rsp_last_q <= issue_last;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            addr_q     <= mb.req_addr;
            strobe_q   <= mb.req_write;
            issue_rd   <= !mb.req_write;
            issue_last <= !mb.req_write;
            if (mb.req_write) begin
              wdata_q <= mb.req_wdata;
            end
`ifdef MEMBUS_BURST_EN
            if (burst_start) begin
              issue_last <= 1'b0;
              ready_q    <= 1'b0;
              state      <= BURST;
            end
`endif
          end
        end
`ifdef MEMBUS_BURST_EN
        BURST: begin
          // One idle cycle after the final beat before taking the next request.
          if (ctr_done) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            addr_q     <= ctr_addr;
            issue_rd   <= 1'b1;
            issue_last <= ctr_last;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_membus_master.sv
// Randomized and directed bench for membus_master against a transaction-level bus model.
module tb_membus_master;

`ifdef MEMBUS_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif
  localparam logic [8:0] LAST_MAPPED = 9'h101;

  typedef struct {
    logic [8:0]  addr;
    logic        wr;
    logic [15:0] data;
  } iss_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        known;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  always #5 clk = ~clk;

  membus_master_if #(.width(16), .ADDR_W(9), .LEN_W(8)) mb ();

  membus_master #(.width(16), .ADDR_W(9), .LEN_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .mb   (mb)
  );

  // Responder: RAM + GPIO words, read data registered one edge after the address.
  logic [15:0] mem [0:257];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 258; i++) mem[i] <= '0;
    end else if (mb.bus_addr <= LAST_MAPPED) begin
      mb.bus_data_read <= mem[mb.bus_addr];
      if (mb.bus_w_strobe) mem[mb.bus_addr] <= mb.bus_data_write;
    end else begin
      mb.bus_data_read <= 'x;
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:257];
  iss_t        exp_iss [int];
  rsp_t        exp_rsp [int];
  logic [8:0]  last_addr;
  int          ready_low_until;
  logic [15:0] got_rsp [$];
  int          cyc;
  logic        rst_s;
  int          n_chk;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    iss_t e;
    rsp_t r;
    if (rst_s) begin
      exp_iss.delete();
      exp_rsp.delete();
      last_addr       = '0;
      ready_low_until = cyc;
      check("rst_req_ready", mb.req_ready, 0);
      check("rst_w_strobe", mb.bus_w_strobe, 0);
      check("rst_rsp_valid", mb.rsp_valid, 0);
      check("rst_rsp_last", mb.rsp_last, 0);
      check("rst_bus_addr", mb.bus_addr, 0);
      check("rst_data_write", mb.bus_data_write, 0);
      return;
    end
    check("req_ready", mb.req_ready, cyc > ready_low_until);
    if (exp_iss.exists(cyc)) begin
      e = exp_iss[cyc];
      exp_iss.delete(cyc);
      check("issue_strobe", mb.bus_w_strobe, e.wr);
      check("issue_addr", mb.bus_addr, e.addr);
      if (e.wr) check("issue_wdata", mb.bus_data_write, e.data);
      last_addr = e.addr;
    end else begin
      check("idle_strobe", mb.bus_w_strobe, 0);
      check("idle_addr_hold", mb.bus_addr, last_addr);
    end
    if (exp_rsp.exists(cyc)) begin
      r = exp_rsp[cyc];
      exp_rsp.delete(cyc);
      check("rsp_valid", mb.rsp_valid, 1);
      check("rsp_last", mb.rsp_last, r.last);
      if (r.known) check("rsp_rdata", mb.rsp_rdata, r.data);
      got_rsp.push_back(mb.rsp_rdata);
    end else begin
      check("rsp_valid_idle", mb.rsp_valid, 0);
    end
  endtask

  task automatic step();
    rst_s = reset;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  // A request taken at edge e issues beats at e, e+1, ... and answers reads one cycle later.
  task automatic model_accept(input int e, input logic wr, input logic [8:0] a,
                              input logic [15:0] d, input logic [7:0] len);
    int         beats;
    logic [8:0] ab;
    beats = (BURST_EN && !wr) ? int'(len) + 1 : 1;
    for (int b = 0; b < beats; b++) begin
      ab = a + 9'(b);
      exp_iss[e + b] = '{addr: ab, wr: wr, data: d};
      if (wr) begin
        if (ab <= LAST_MAPPED) ref_mem[ab] = d;
      end else begin
        exp_rsp[e + b + 1] = '{data: (ab <= LAST_MAPPED) ? ref_mem[ab] : 16'h0,
                               last: (b == beats - 1), known: (ab <= LAST_MAPPED)};
      end
    end
    if (beats > 1) ready_low_until = e + beats - 1;
  endtask

  task automatic send(input logic wr, input logic [8:0] a, input logic [15:0] d, input logic [7:0] len);
    int waited;
    waited = 0;
    mb.req_valid = 1'b1;
    mb.req_write = wr;
    mb.req_addr  = a;
    mb.req_wdata = d;
    mb.req_len   = len;
    while (mb.req_ready !== 1'b1) begin
      if (waited > 50) begin
        check("req_ready_timeout", 0, 1);
        mb.req_valid = 1'b0;
        return;
      end
      waited++;
      step();
    end
    model_accept(cyc + 1, wr, a, d, len);
    step();
    mb.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    mb.req_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int          sel;
    logic [8:0]  a;
    logic        wr;
    logic [7:0]  len;

    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    last_addr = '0;
    ready_low_until = 0;
    for (int i = 0; i < 258; i++) ref_mem[i] = '0;
    reset = 1'b1;
    mem_clr = 1'b1;
    mb.req_valid = 1'b0;
    mb.req_write = 1'b0;
    mb.req_addr = '0;
    mb.req_wdata = '0;
    mb.req_len = '0;
    repeat (3) step();
    reset = 1'b0;
    mem_clr = 1'b0;
    step();

    // Write then read the same RAM word.
    got_rsp.delete();
    send(1'b1, 9'h005, 16'hBEEF, 8'd0);
    send(1'b0, 9'h005, 16'h0, 8'd0);
    idle(3);
    check("t1_rsp_count", got_rsp.size(), 1);
    check("t1_rdata", got_rsp[0], 16'hBEEF);

    // Back-to-back reads of preloaded words.
    send(1'b1, 9'h010, 16'h1111, 8'd0);
    send(1'b1, 9'h011, 16'h2222, 8'd0);
    send(1'b1, 9'h012, 16'h3333, 8'd0);
    idle(1);
    got_rsp.delete();
    send(1'b0, 9'h010, 16'h0, 8'd0);
    send(1'b0, 9'h011, 16'h0, 8'd0);
    send(1'b0, 9'h012, 16'h0, 8'd0);
    idle(3);
    check("t2_rsp_count", got_rsp.size(), 3);
    check("t2_rdata0", got_rsp[0], 16'h1111);
    check("t2_rdata1", got_rsp[1], 16'h2222);
    check("t2_rdata2", got_rsp[2], 16'h3333);

    // Read immediately followed by a write to the same word.
    got_rsp.delete();
    send(1'b0, 9'h020, 16'h0, 8'd0);
    send(1'b1, 9'h020, 16'h5A5A, 8'd0);
    idle(2);
    send(1'b0, 9'h020, 16'h0, 8'd0);
    idle(3);
    check("t3_rsp_count", got_rsp.size(), 2);
    check("t3_old_value", got_rsp[0], 16'h0000);
    check("t3_new_value", got_rsp[1], 16'h5A5A);

    // GPIO register.
    got_rsp.delete();
    send(1'b1, 9'h100, 16'h00FF, 8'd0);
    send(1'b0, 9'h100, 16'h0, 8'd0);
    idle(3);
    check("t4_gpio_rdata", got_rsp[0], 16'h00FF);

    // Reset the cycle after a read is accepted: the response must vanish.
    got_rsp.delete();
    send(1'b0, 9'h030, 16'h0, 8'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    idle(3);
    check("t5_rsp_after_reset", got_rsp.size(), 0);

    // Burst across the RAM/GPIO boundary, then across the address wrap.
    send(1'b1, 9'h101, 16'h4242, 8'd0);
    send(1'b1, 9'h0FF, 16'h0F0F, 8'd0);
    idle(1);
    got_rsp.delete();
    send(1'b0, 9'h0FE, 16'h0, 8'd3);
    idle(6);
    check("t6_burst_beats", got_rsp.size(), BURST_EN ? 4 : 1);
    check("t6_beat0", got_rsp[0], 16'h0000);
    got_rsp.delete();
    send(1'b0, 9'h1FF, 16'h0, 8'd1);
    idle(4);
    check("t6_wrap_beats", got_rsp.size(), BURST_EN ? 2 : 1);

    // Random traffic with hazards around the map edges.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) a = 9'($urandom);
      else if (sel == 1) a = 9'h1FC + 9'($urandom_range(0, 3));
      else a = 9'h0F8 + 9'($urandom_range(0, 15));
      wr = ($urandom_range(0, 2) == 0);
      len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      send(wr, a, 16'($urandom), len);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(8);
    check("pending_issues_left", exp_iss.num(), 0);
    check("pending_rsps_left", exp_rsp.num(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/membus_master.md
Name: membus_master

Overview:
- Bus initiator that drives the 9-bit-address memory/GPIO bus from the requester side.
- Accepts word requests over a valid/ready handshake and issues one registered bus cycle per request.
- Tracks the bus's fixed one-cycle read latency and returns read data on a response channel.
- Sits between a requester (CPU core or debug/UART bridge) and the bus responder; fully pipelined single-word reads, optional bursts.

Parameters:
- width, 16, data word width; must match the responder.
- ADDR_W, 9, bus address width (fixed map: 0x000-0x0FF RAM, 0x100-0x101 GPIO).
- LEN_W, 8, burst length field width (used only with MEMBUS_BURST_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  width  write data.
- req_len  in  LEN_W  burst beats minus 1; ignored unless MEMBUS_BURST_EN.
- rsp_valid  out  1  read data valid this cycle; no backpressure.
- rsp_rdata  out  width  read data.
- rsp_last  out  1  final beat of a read (always 1 without bursts).
- bus_addr  out  ADDR_W  to responder addr.
- bus_data_write  out  width  to responder data_write.
- bus_w_strobe  out  1  to responder w_strobe.
- bus_data_read  in  width  from responder data_read; valid the cycle after bus_addr is presented.

Behaviour:
- Reset values: req_ready=0 during reset, 1 the first cycle after; rsp_valid=0, rsp_last=0, bus_w_strobe=0, bus_addr=0, bus_data_write=0, state=IDLE, pending-read pipe cleared.
- Bus outputs are registered. A request accepted at edge k drives bus_addr/bus_w_strobe/bus_data_write during cycle k+1 (the "issue cycle").
- Write: bus_w_strobe=1 for exactly the issue cycle, with bus_addr=req_addr and bus_data_write=req_wdata. No response is generated.
- Read: bus_w_strobe=0 in the issue cycle. A 1-deep pending flag is registered at edge k+1, so rsp_valid=1 in cycle k+2.
  - rsp_rdata = bus_data_read (combinational pass-through); rsp_last=1.
  - Request-accept to rsp_valid latency is exactly 2 cycles.
- In IDLE, req_ready=1. Back-to-back requests are accepted every cycle, yielding one bus cycle per clock.
- Mixed read-then-write: responses always appear in issue order. The write cannot corrupt a pending read response, since read data is captured by the responder one edge earlier.
- When no request is accepted, the issue cycle has bus_w_strobe=0 and bus_addr holds its last value.
- Unmapped addresses (0x102-0x1FF) are issued unchanged. Read data is undefined (X from responder) but rsp_valid still pulses; writes are silently dropped by the responder.
- States: IDLE; BURST (only with MEMBUS_BURST_EN).
- Reset asserted mid-operation: abort immediately. Any pending rsp_valid is dropped; bus_w_strobe=0 on the next cycle.

Optional Feature:
- Macro: MEMBUS_BURST_EN.
- With the macro, a read request with req_len=N>0:
  - enters BURST with req_ready=0;
  - issues N+1 consecutive reads at addr, addr+1, ... in consecutive cycles, address wrapping modulo 2^ADDR_W (0x1FF -> 0x000);
  - produces N+1 responses in consecutive cycles, rsp_last=1 only on the final beat;
  - req_ready returns to 1 in the cycle after the last address is issued.
- Write requests ignore req_len (single beat) in both configurations.
- Without the macro: req_len is ignored, there is no BURST state, and every request is a single beat.

Decomposition:
- Package membus_pkg holds:
  - ADDR_W, RAM_BASE=9'h000, RAM_LAST=9'h0FF, GPIO_BASE=9'h100;
  - state enum {IDLE, BURST};
  - a request struct {write, addr, wdata, len}.
- The burst address/beat counter is a natural sub-module, membus_burst_ctr: load, decrement, wrap, last flag. It is instantiated only under MEMBUS_BURST_EN.

Test Plan:
- Write 0xBEEF to 0x005, then read 0x005: bus_w_strobe high exactly one cycle with addr 0x005; rsp_valid 2 cycles after read accept with rsp_rdata=0xBEEF, rsp_last=1.
- Back-to-back reads of 0x010, 0x011, 0x012 (preloaded 0x1111, 0x2222, 0x3333): req_ready stays 1; rsp_valid high for 3 consecutive cycles with data in order.
- Read 0x020, then write 0x020 with 0x5A5A the next cycle: read response returns the old value 0x0000; a later read returns 0x5A5A.
- GPIO: write 0x00FF to 0x100, read 0x100: bus_w_strobe with addr 0x100; rsp_rdata reflects the GPIO register.
- Reset asserted the cycle after a read is accepted: no rsp_valid; bus_w_strobe=0; req_ready=0 during reset, 1 the cycle after release.
- MEMBUS_BURST_EN: read 0x0FE with req_len=3 gives addrs 0x0FE, 0x0FF, 0x100, 0x101; 4 rsp_valid beats, rsp_last only on the 4th; req_ready low 4 cycles. Read 0x1FF with req_len=1 gives addrs 0x1FF, then 0x000.
